// File: rtl/enc4to2_latch_pkg.sv
// Shared definitions for the latching 4-to-2 priority encoder: state encodings,
// widths, the captured-request payload and a small popcount helper.
package enc4to2_latch_pkg;

    localparam int unsigned REQ_W     = 4;
    localparam int unsigned IDX_W     = 2;
    localparam int unsigned POP_W     = 3;
    localparam int unsigned CNT_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_UNUSED  = 2'd3
    } state_e;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             multi;
    } capture_t;

    function automatic logic [POP_W-1:0] popcount4(input logic [REQ_W-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < int'(REQ_W); i++) begin
            n = n + POP_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/enc4to2_latch_prio_enc4.sv
// Combinational 4-input priority encoder: bit 3 wins; also flags any/multiple requests.
module prio_enc4
    import enc4to2_latch_pkg::*;
(
    input  logic [REQ_W-1:0] d_i,
    output logic [IDX_W-1:0] idx_c,
    output logic             any_c,
    output logic             multi_c
);

    always_comb begin
        idx_c = 2'd0;
        if (d_i[3]) begin
            idx_c = 2'd3;
        end else if (d_i[2]) begin
            idx_c = 2'd2;
        end else if (d_i[1]) begin
            idx_c = 2'd1;
        end
    end

    assign any_c   = |d_i;
    assign multi_c = (popcount4(d_i) > POP_W'(1));

endmodule

// File: rtl/enc4to2_latch.sv
// Registered priority encoder with capture latching, ack handshake and a
// release-before-rearm guard so a held request is reported only once.
module enc4to2_latch
    import enc4to2_latch_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [REQ_W-1:0] d_in,
    input  logic             ack,
    output logic [IDX_W-1:0] enc_out,
    output logic             valid,
    output logic             multi,
    output logic [CNT_W-1:0] evt_cnt
);

    state_e           state_q, state_d;
    capture_t         cap_q, cap_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [IDX_W-1:0] idx_c;
    logic             any_c;
    logic             multi_c;

    prio_enc4 u_prio (
        .d_i     (d_in),
        .idx_c   (idx_c),
        .any_c   (any_c),
        .multi_c (multi_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cap_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: captures only from IDLE; RELEASE waits for all lines low.
    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (en && any_c) begin
                    cap_d.idx   = idx_c;
                    cap_d.multi = multi_c;
                    valid_d     = 1'b1;
                    cnt_d       = cnt_q + CNT_W'(1);
                    state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (ack) begin
                    valid_d = 1'b0;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!any_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign enc_out = cap_q.idx;
    assign multi   = cap_q.multi;
    assign valid   = valid_q;
    assign evt_cnt = cnt_q;

endmodule
